// File: rtl/crossbar_pkg.sv
// Shared types and constants for the banked crossbar: FSM state encoding and
// the bitwidth-to-shift decode used by the per-lane bank mapping.
package crossbar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } xbar_state_e;

  // Mode 3 has no mapping of its own and folds onto the widest shift.
  localparam logic [1:0] S_MAX = 2'd2;

  function automatic logic [1:0] decode_shift(input logic [1:0] bw);
    return (bw > S_MAX) ? S_MAX : bw;
  endfunction

endpackage

// File: rtl/crossbar_bank_map.sv
// Combinational lane-to-bank hash: skews rows across banks so that a row
// sweep and a column sweep both spread over distinct accumulator banks.
module crossbar_bank_map #(
  parameter int BANK_COUNT = 256,
  parameter int TILE_SIZE  = 256,
  localparam int CW = $clog2(TILE_SIZE),
  localparam int BW = $clog2(BANK_COUNT)
) (
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [1:0]    shift,
  output logic [BW-1:0] bank
);

  // Wide enough that no term or the sum wraps before the final modulo.
  localparam int W = ((CW > BW) ? CW : BW) + 3;

  logic [W-1:0] row_w;
  logic [W-1:0] hi_term;
  logic [W-1:0] lo_term;
  logic [W-1:0] sum;

  always_comb begin
    row_w   = W'(row);
    hi_term = (row_w >> shift) * W'(3);
    lo_term = (row_w & ((W'(1) << shift) - W'(1))) * (W'(BANK_COUNT) >> shift);
    sum     = W'(col) + hi_term + lo_term;
    bank    = sum[BW-1:0];
  end

endmodule

// File: rtl/banked_crossbar.sv
// Routes up to N_INPUTS product lanes per transaction onto BANK_COUNT banks,
// one write per bank per cycle. Optional CROSSBAR_PERF_EN adds conflict_cycles.
module banked_crossbar
  import crossbar_pkg::*;
#(
  parameter int N_INPUTS   = 16,
  parameter int BANK_COUNT = 256,
  parameter int TILE_SIZE  = 256,
  parameter int PROD_W     = 64,
  parameter int DATA_W     = 8,
  localparam int CW = $clog2(TILE_SIZE),
  localparam int BW = $clog2(BANK_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_INPUTS-1:0]   in_mask,
  input  logic [1:0]            bitwidth,
  input  logic [PROD_W-1:0]     products          [N_INPUTS],
  input  logic [CW-1:0]         row_coordinate    [N_INPUTS],
  input  logic [CW-1:0]         column_coordinate [N_INPUTS],
  output logic [CW-1:0]         buffer_row_write    [BANK_COUNT],
  output logic [CW-1:0]         buffer_column_write [BANK_COUNT],
  output logic [DATA_W-1:0]     buffer_data_write   [BANK_COUNT],
  output logic [BANK_COUNT-1:0] buffer_write_enable,
  output logic                  crossbar_stall
`ifdef CROSSBAR_PERF_EN
  , output logic [15:0]         conflict_cycles
`endif
);

  xbar_state_e state, state_n;

  logic [N_INPUTS-1:0] pending_p0;
  logic [DATA_W-1:0]   data_p0  [N_INPUTS];
  logic [CW-1:0]       row_p0   [N_INPUTS];
  logic [CW-1:0]       col_p0   [N_INPUTS];
  logic [1:0]          shift_p0;

  logic [BW-1:0]         bank    [N_INPUTS];
  logic [N_INPUTS-1:0]   grant;
  logic [BANK_COUNT-1:0] claimed;
  logic                  accept;
  logic                  leftover;

  assign in_ready       = (state == IDLE);
  assign crossbar_stall = (state == ROUTE);
  assign accept         = in_valid && (state == IDLE);

  // ---- stage p0: transaction capture ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending_p0 <= '0;
    end else begin
      state <= state_n;
      if (accept)
        pending_p0 <= in_mask;
      else if (state == ROUTE)
        pending_p0 <= pending_p0 & ~grant;
    end
  end

  // Payload is only meaningful while pending bits are set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_p0 <= decode_shift(bitwidth);
      for (int i = 0; i < N_INPUTS; i++) begin
        data_p0[i] <= {products[i][PROD_W-1], products[i][DATA_W-2:0]};
        row_p0[i]  <= row_coordinate[i];
        col_p0[i]  <= column_coordinate[i];
      end
    end
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_map
    crossbar_bank_map #(
      .BANK_COUNT(BANK_COUNT),
      .TILE_SIZE (TILE_SIZE)
    ) u_map (
      .row  (row_p0[g]),
      .col  (col_p0[g]),
      .shift(shift_p0),
      .bank (bank[g])
    );
  end

  // Fixed priority: the lowest pending lane wins each bank this cycle.
  always_comb begin
    claimed = '0;
    grant   = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if ((state == ROUTE) && pending_p0[i] && !claimed[bank[i]]) begin
        grant[i]         = 1'b1;
        claimed[bank[i]] = 1'b1;
      end
    end
  end

  assign leftover = |(pending_p0 & ~grant);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && (in_mask != '0)) state_n = ROUTE;
      ROUTE:   if (!leftover) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p1: bank write registers ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buffer_write_enable <= '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
        buffer_row_write[b]    <= '0;
        buffer_column_write[b] <= '0;
        buffer_data_write[b]   <= '0;
      end
    end else begin
      buffer_write_enable <= claimed;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (grant[i]) begin
          buffer_row_write[bank[i]]    <= row_p0[i];
          buffer_column_write[bank[i]] <= col_p0[i];
          buffer_data_write[bank[i]]   <= data_p0[i];
        end
      end
    end
  end

`ifdef CROSSBAR_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      conflict_cycles <= '0;
    else if ((state == ROUTE) && leftover && (conflict_cycles != 16'hFFFF))
      conflict_cycles <= conflict_cycles + 16'd1;
  end
`endif

endmodule
